// File: rtl/tile_pkg.sv
// tile_pkg
// Shared layout and encoding definitions for the 2x2 game tile board.
// Game control, the tile LUT and tile_plotter import this package, so tile
// positions and colours are defined only here.
//
// Contents:
//   tile_code_t      2-bit tile code (0=q, 1=w, 2=a, 3=s)
//   COORD_W          width of the per-tile cx/cy sweep offsets
//   ORIGIN_X/Y       top-left pixel of each tile, indexed by tile code
//   NORMAL_COLOUR    resting colour of each tile, indexed by tile code
//   FLASH_COLOUR     colour used for the highlight sweep
//   BORDER_COLOUR    outline colour used when tile borders are enabled
//   plot_state_t     tile_plotter FSM states
package tile_pkg;

  typedef logic [1:0] tile_code_t;

  // Offsets run up to 31, which covers the largest supported tile edge.
  localparam int COORD_W = 5;

  localparam logic [7:0] ORIGIN_X [0:3] = '{8'd50, 8'd90, 8'd50, 8'd90};
  localparam logic [7:0] ORIGIN_Y [0:3] = '{8'd30, 8'd30, 8'd70, 8'd70};

  localparam logic [2:0] NORMAL_COLOUR [0:3] = '{3'b100, 3'b010, 3'b001, 3'b110};

  localparam logic [2:0] FLASH_COLOUR  = 3'b111;
  localparam logic [2:0] BORDER_COLOUR = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAW_ON,
    ST_HOLD,
    ST_DRAW_OFF,
    ST_DONE
  } plot_state_t;

endpackage

// File: rtl/tile_sweep_counter.sv
// tile_sweep_counter
// Raster offset generator for one tile: cx runs fastest, cy advances when
// cx wraps. After the final pixel both offsets wrap back to 0, so the same
// counter can immediately serve a second sweep of the tile.
//
// Ports:
//   clock    system clock
//   resetn   asynchronous active-low reset
//   clear    synchronous return to (0,0); dominates enable
//   enable   advance one pixel
//   cx, cy   current offsets inside the tile
//   last     high while (cx,cy) is the final pixel of the tile
module tile_sweep_counter
  import tile_pkg::*;
#(
  parameter int TILE_SIZE = 20
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               clear,
  input  logic               enable,
  output logic [COORD_W-1:0] cx,
  output logic [COORD_W-1:0] cy,
  output logic               last
);

  localparam logic [COORD_W-1:0] CMAX = COORD_W'(TILE_SIZE - 1);

  // Raster advance with wrap on both axes at the tile edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cx <= '0;
      cy <= '0;
    end else if (clear) begin
      cx <= '0;
      cy <= '0;
    end else if (enable) begin
      if (cx == CMAX) begin
        cx <= '0;
        cy <= (cy == CMAX) ? '0 : cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

  assign last = (cx == CMAX) && (cy == CMAX);

endmodule

// File: rtl/tile_plotter.sv
// tile_plotter
// Paints one of the four game tiles into the vga_adapter frame buffer. A
// normal request sweeps the tile once in its own colour; a flash request
// sweeps it white, waits HOLD_CYCLES clocks, then sweeps it back to its
// normal colour. All outputs are registered.
//
// Build option: define TILE_BORDER_EN to paint the outer ring of every
// sweep in BORDER_COLOUR. Pixel count and timing are unchanged.
//
// Ports:
//   clock     system clock
//   resetn    asynchronous active-low reset
//   start     request pulse, only honoured in IDLE
//   tile      tile code, latched with start
//   flash     0 = single normal sweep, 1 = white/hold/restore, latched
//   abort     cancel any operation in progress (no done pulse)
//   x, y      pixel coordinate to vga_adapter
//   colour    pixel colour
//   plot      frame buffer write enable
//   busy      operation in progress
//   done      one-cycle completion pulse
module tile_plotter
  import tile_pkg::*;
#(
  parameter int HOLD_CYCLES = 12_500_000,
  parameter int TILE_SIZE   = 20
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [1:0] tile,
  input  logic       flash,
  input  logic       abort,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam logic [23:0]        HOLD_LAST = 24'(HOLD_CYCLES - 1);
  localparam logic [COORD_W-1:0] CMAX      = COORD_W'(TILE_SIZE - 1);

  plot_state_t        state, next_state;
  tile_code_t         tile_q;
  logic               flash_q;
  logic [23:0]        hold_cnt;
  logic [COORD_W-1:0] cx, cy;
  logic               last;
  logic               drawing;
  logic [2:0]         sweep_colour;
  logic [2:0]         pixel_colour;

  assign drawing = (state == ST_DRAW_ON) || (state == ST_DRAW_OFF);

  // One counter serves both sweeps: it wraps to (0,0) after the last pixel
  // and is forced back to (0,0) while idle so an aborted sweep never leaks
  // its position into the next request.
  tile_sweep_counter #(
    .TILE_SIZE(TILE_SIZE)
  ) u_sweep (
    .clock (clock),
    .resetn(resetn),
    .clear (state == ST_IDLE),
    .enable(drawing),
    .cx    (cx),
    .cy    (cy),
    .last  (last)
  );

  // State register plus request latch. tile/flash are captured only on the
  // accepting edge, so a start seen mid-operation cannot relatch them. The
  // hold counter runs only while in HOLD and restarts from 0 otherwise.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      tile_q   <= '0;
      flash_q  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == ST_IDLE && start) begin
        tile_q  <= tile;
        flash_q <= flash;
      end
      hold_cnt <= (state == ST_HOLD) ? hold_cnt + 1'b1 : '0;
    end
  end

  // Next-state logic. Abort overrides every non-idle transition; in IDLE it
  // is not looked at, so a simultaneous start is still accepted.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     if (start) next_state = ST_DRAW_ON;
      ST_DRAW_ON:  if (last) next_state = flash_q ? ST_HOLD : ST_DONE;
      ST_HOLD:     if (hold_cnt == HOLD_LAST) next_state = ST_DRAW_OFF;
      ST_DRAW_OFF: if (last) next_state = ST_DONE;
      ST_DONE:     next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
    if (state != ST_IDLE && abort) next_state = ST_IDLE;
  end

  // Only the first sweep of a flash request is white; the restoring sweep
  // and every normal request use the tile's own colour.
  always_comb begin
    sweep_colour = (state == ST_DRAW_ON && flash_q) ? FLASH_COLOUR
                                                    : NORMAL_COLOUR[tile_q];
`ifdef TILE_BORDER_EN
    pixel_colour = (cx == '0 || cy == '0 || cx == CMAX || cy == CMAX)
                   ? BORDER_COLOUR : sweep_colour;
`else
    pixel_colour = sweep_colour;
`endif
  end

  // Registered outputs, one cycle behind the state that produces them. An
  // abort clears plot/busy/done on the same edge that returns to IDLE;
  // coordinates and colour keep their last values whenever nothing is
  // being plotted.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      plot <= drawing && !abort;
      busy <= (state != ST_IDLE) && !abort;
      done <= (state == ST_DONE) && !abort;
      if (drawing && !abort) begin
        x      <= ORIGIN_X[tile_q] + 8'(cx);
        y      <= ORIGIN_Y[tile_q] + 8'(cy);
        colour <= pixel_colour;
      end
    end
  end

endmodule

// File: tb/tb_tile_plotter.sv
// tb_tile_plotter
// Self-checking bench for tile_plotter with a short flash hold. A table of
// requests is replayed in order; for each request the expected pixel stream
// is queued up front and popped as the DUT plots, while plot/busy/done are
// compared every cycle against the expected cycle-accurate waveform.
// Honours TILE_BORDER_EN when the design is built with it.
module tb_tile_plotter;

  localparam int HOLD = 5;
  localparam int TS   = 20;
  localparam int N    = TS * TS;
`ifdef TILE_BORDER_EN
  localparam bit BORDER    = 1'b1;
  localparam int EXP_BLACK = 4 * TS - 4;
`else
  localparam bit BORDER    = 1'b0;
  localparam int EXP_BLACK = 0;
`endif

  logic       clock = 1'b0;
  logic       resetn;
  logic       start;
  logic [1:0] tile;
  logic       flash;
  logic       abort;
  logic [7:0] x, y;
  logic [2:0] colour;
  logic       plot, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } pix_t;

  typedef struct {
    logic [1:0] tile;
    logic       flash;
    int         interfere_at;
    int         abort_at;
    int         exp_done;
  } vec_t;

  pix_t exp_q[$];
  vec_t vecs[7];
  vec_t recover_vec;

  tile_plotter #(
    .HOLD_CYCLES(HOLD),
    .TILE_SIZE  (TS)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .start (start),
    .tile  (tile),
    .flash (flash),
    .abort (abort),
    .x     (x),
    .y     (y),
    .colour(colour),
    .plot  (plot),
    .busy  (busy),
    .done  (done)
  );

  always #5 clock = ~clock;

  // Independent copy of the board layout.
  function automatic logic [7:0] exp_ox(input logic [1:0] t);
    case (t)
      2'd0, 2'd2: exp_ox = 8'd50;
      default:    exp_ox = 8'd90;
    endcase
  endfunction

  function automatic logic [7:0] exp_oy(input logic [1:0] t);
    case (t)
      2'd0, 2'd1: exp_oy = 8'd30;
      default:    exp_oy = 8'd70;
    endcase
  endfunction

  function automatic logic [2:0] exp_colour(input logic [1:0] t);
    case (t)
      2'd0:    exp_colour = 3'b100;
      2'd1:    exp_colour = 3'b010;
      2'd2:    exp_colour = 3'b001;
      default: exp_colour = 3'b110;
    endcase
  endfunction

  task automatic checkOutput(input string name, input int cyc,
                             input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_sweep(input logic [1:0] t, input logic [2:0] c);
    pix_t p;
    for (int py = 0; py < TS; py++) begin
      for (int px = 0; px < TS; px++) begin
        p.x = exp_ox(t) + 8'(px);
        p.y = exp_oy(t) + 8'(py);
        if (BORDER && (px == 0 || py == 0 || px == TS - 1 || py == TS - 1))
          p.c = 3'b000;
        else
          p.c = c;
        exp_q.push_back(p);
      end
    end
  endtask

  // Called just after a falling edge; start is sampled on the next rising
  // edge (cycle 0). Returns just after the falling edge of the final
  // checked cycle.
  task automatic applyStimulus(input vec_t v);
    int   last_cyc;
    int   black;
    pix_t p;
    logic e_plot, e_busy, e_done;

    exp_q.delete();
    push_sweep(v.tile, v.flash ? 3'b111 : exp_colour(v.tile));
    if (v.flash) push_sweep(v.tile, exp_colour(v.tile));
    last_cyc = (v.abort_at >= 0) ? v.abort_at + 5 : v.exp_done + 1;
    black = 0;

    tile  = v.tile;
    flash = v.flash;
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;

    for (int c = 1; c <= last_cyc; c++) begin
      @(negedge clock);
      if (v.abort_at >= 0 && c > v.abort_at) begin
        e_plot = 1'b0;
        e_busy = 1'b0;
        e_done = 1'b0;
      end else begin
        if (v.flash)
          e_plot = (c <= N) || (c >= N + HOLD + 1 && c <= 2 * N + HOLD);
        else
          e_plot = (c <= N);
        e_busy = (c <= v.exp_done);
        e_done = (c == v.exp_done);
      end
      checkOutput("plot_busy_done", c, 32'({plot, busy, done}), 32'({e_plot, e_busy, e_done}));

      if (plot) begin
        if (exp_q.size() == 0) begin
          checkOutput("extra_pixel", c, 32'({x, y, colour}), 32'hFFFF_FFFF);
        end else begin
          p = exp_q.pop_front();
          checkOutput("pixel_xyc", c, 32'({x, y, colour}), 32'(p));
        end
        if (colour == 3'b000) black++;
      end

      if (c == v.interfere_at) begin
        start = 1'b1;
        tile  = 2'd3;
        flash = ~v.flash;
      end else if (c == v.interfere_at + 1) begin
        start = 1'b0;
      end

      if (c == v.abort_at) abort = 1'b1;
      else if (c == v.abort_at + 1) abort = 1'b0;
    end

    if (v.abort_at >= 0) begin
      exp_q.delete();
    end else begin
      checkOutput("pixels_left", last_cyc, 32'(exp_q.size()), 32'd0);
      if (!v.flash) checkOutput("black_count", last_cyc, 32'(black), 32'(EXP_BLACK));
    end
  endtask

  initial begin
    // tile, flash, interfere_at, abort_at, exp_done
    vecs[0] = '{2'd2, 1'b0,  -1,  -1, N + 1};
    vecs[1] = '{2'd1, 1'b1,  -1,  -1, 2 * N + HOLD + 1};
    vecs[2] = '{2'd0, 1'b0, 100,  -1, N + 1};
    vecs[3] = '{2'd3, 1'b0,  -1,  -1, N + 1};
    vecs[4] = '{2'd1, 1'b1,  -1, 200, 2 * N + HOLD + 1};
    vecs[5] = '{2'd3, 1'b0,  -1,  -1, N + 1};
    vecs[6] = '{2'd0, 1'b0,  -1,  -1, N + 1};
    recover_vec = '{2'd2, 1'b1, -1, -1, 2 * N + HOLD + 1};

    resetn = 1'b0;
    start  = 1'b0;
    tile   = 2'd0;
    flash  = 1'b0;
    abort  = 1'b0;

    #23;
    checkOutput("reset_outputs", 0, 32'({x, y, colour, plot, busy, done}), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      checkOutput("idle_outputs", c, 32'({x, y, colour, plot, busy, done}), 32'd0);
    end

    for (int i = 0; i < 7; i++) begin
      $display("[TB] request %0d: tile %0d flash %0d", i, vecs[i].tile, vecs[i].flash);
      applyStimulus(vecs[i]);
    end

    // Asynchronous reset in the middle of a sweep.
    tile  = 2'd2;
    flash = 1'b0;
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (30) @(negedge clock);
    #2 resetn = 1'b0;
    #1 checkOutput("async_reset", 0, 32'({x, y, colour, plot, busy, done}), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      checkOutput("post_reset_idle", c, 32'({plot, busy, done}), 32'd0);
    end
    applyStimulus(recover_vec);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
